data_bus_sink_fifo: RTL and testbench

- Destination-domain stage placed directly downstream of data_bus_synchro.
- data_bus_synchro delivers words as valid-only pulses on tvalid_o/tdata_o, with no backpressure. This block catches those words in a small FIFO.
- It re-presents them as a full valid/ready stream to destination logic.
- It reports fill level, almost-full and a sticky overflow flag, so upstream throttling can be checked.

---
 rtl/data_bus_sink_fifo.sv | 153 +++++++++++++++
 tb/tb_data_bus_sink_fifo.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/data_bus_sink_fifo.sv
// -----------------------------------------------------------------------------
// data_bus_sink_fifo
//
// Destination-domain catch FIFO that sits directly after data_bus_synchro.
// The synchroniser hands over words as single-cycle valid pulses with no way
// to push back, so every pulse must be stored immediately or it is lost. This
// block stores the words in a small register-array FIFO and re-presents them
// to destination logic as a full valid/ready stream. It also reports fill level,
// almost-full and a sticky overflow flag, so upstream throttling can be checked.
//
// Handshake: on the output side a word transfers on every rising aclk edge
// where tvalid_o=1 and tready_o=1. Once tvalid_o is raised, it and tdata_o
// hold until that transfer happens. The input side has no ready. A tvalid_i
// pulse is either accepted or counted as a drop (overflow).
//
// Ports:
//   aclk          in   destination clock (same as data_bus_synchro aclk_o)
//   srst          in   synchronous reset, active-high
//   tvalid_i      in   input word present (no ready returned)
//   tdata_i       in   input word
//   tvalid_o      out  FIFO not empty
//   tready_o      in   downstream accepts the head word
//   tdata_o       out  head-of-FIFO word, forced to 0 while empty
//   level         out  occupancy 0..DEPTH
//   almost_full   out  level >= AFULL_THRESH
//   overflow      out  sticky: at least one word was dropped
//   overflow_clr  in   clears overflow (a same-cycle drop wins)
// -----------------------------------------------------------------------------
module data_bus_sink_fifo #(
    parameter int BUS_WIDTH    = 8,
    parameter int DEPTH        = 8,
    parameter int AFULL_THRESH = 6
) (
    input  logic                       aclk,
    input  logic                       srst,
    input  logic                       tvalid_i,
    input  logic [BUS_WIDTH-1:0]       tdata_i,
    output logic                       tvalid_o,
    input  logic                       tready_o,
    output logic [BUS_WIDTH-1:0]       tdata_o,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       almost_full,
    output logic                       overflow,
    input  logic                       overflow_clr
);

    // Address bits index the array. One extra MSB acts as the wrap bit, so
    // a full FIFO and an empty FIFO can be told apart without a separate count.
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic                 overflow_q, overflow_d;
    logic [BUS_WIDTH-1:0] mem_q [DEPTH];
    logic [BUS_WIDTH-1:0] mem_d [DEPTH];

    // -------------------------------------------------------------------------
    // Status derived from the pointers
    // -------------------------------------------------------------------------
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [PW-1:0] level_w;

    assign wr_addr = wr_ptr_q[AW-1:0];
    assign rd_addr = rd_ptr_q[AW-1:0];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_addr == rd_addr) && (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);

    // Modular difference of the wrap-bit pointers gives the exact occupancy,
    // including DEPTH when full.
    assign level_w = wr_ptr_q - rd_ptr_q;

    // -------------------------------------------------------------------------
    // Transfer decisions
    // -------------------------------------------------------------------------
    // A pop in the same cycle frees the head slot, so a full FIFO can still
    // take an incoming word while it is emptying.
    assign pop  = !empty && tready_o;
    assign push = tvalid_i && (!full || pop);
    assign drop = tvalid_i && full && !pop;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end

        if (push) begin
            mem_d[wr_addr] = tdata_i;
            wr_ptr_d       = wr_ptr_q + PW'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        // A drop in the same cycle as a clear leaves the flag set, so no
        // loss event is hidden by a clear.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (srst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage has no reset. Stale contents never reach the output, because
    // tdata_o is masked while the FIFO is empty.
    always_ff @(posedge aclk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign tvalid_o    = !empty;
    assign tdata_o     = empty ? '0 : mem_q[rd_addr];
    assign level       = level_w;
    assign almost_full = (level_w >= PW'(AFULL_THRESH));
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_data_bus_sink_fifo.sv
module tb_data_bus_sink_fifo;

    localparam int BUS_WIDTH = 8;
    localparam int DEPTH     = 8;

    logic                 aclk;
    logic                 srst;
    logic                 tvalid_i;
    logic [BUS_WIDTH-1:0] tdata_i;
    logic                 tvalid_o;
    logic                 tready_o;
    logic [BUS_WIDTH-1:0] tdata_o;
    logic [3:0]           level;
    logic                 almost_full;
    logic                 overflow;
    logic                 overflow_clr;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [BUS_WIDTH-1:0] exp_q[$];

    data_bus_sink_fifo #(
        .BUS_WIDTH    (BUS_WIDTH),
        .DEPTH        (DEPTH),
        .AFULL_THRESH (6)
    ) dut (
        .aclk         (aclk),
        .srst         (srst),
        .tvalid_i     (tvalid_i),
        .tdata_i      (tdata_i),
        .tvalid_o     (tvalid_o),
        .tready_o     (tready_o),
        .tdata_o      (tdata_o),
        .level        (level),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    // Clock / reset
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Checking
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drivers: advance one edge and settle past it.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic write_word(input logic [7:0] d);
        tvalid_i = 1'b1;
        tdata_i  = d;
        tick();
        tvalid_i = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tvalid"}, 32'(tvalid_o), 32'd0);
        check({tag, "_level"},  32'(level),    32'd0);
        check({tag, "_ovf"},    32'(overflow), 32'd0);
        check({tag, "_tdata"},  32'(tdata_o),  32'h00);
    endtask

    // Drain with tready_o=1, requiring the given sequence in order.
    task automatic drain_expect(input string tag);
        tready_o = 1'b1;
        while (exp_q.size() > 0) begin
            check({tag, "_tvalid"}, 32'(tvalid_o), 32'd1);
            check({tag, "_tdata"},  32'(tdata_o),  32'(exp_q.pop_front()));
            tick();
        end
        tready_o = 1'b0;
        check({tag, "_level0"}, 32'(level), 32'd0);
    endtask

    initial begin
        int rx_cnt;
        int k;

        srst = 1'b1; tvalid_i = 1'b1; tdata_i = 8'hAA;
        tready_o = 1'b0; overflow_clr = 1'b0;

        // Reset held for 5 cycles with input activity that must be ignored.
        for (int i = 0; i < 5; i++) begin
            tick();
            check_idle("rst");
        end
        srst = 1'b0; tvalid_i = 1'b0; tdata_i = 8'h00;
        tick();
        check_idle("post_rst");

        // Single word.
        write_word(8'h5C);
        check("single_tvalid", 32'(tvalid_o), 32'd1);
        check("single_tdata",  32'(tdata_o),  32'h5C);
        check("single_level",  32'(level),    32'd1);
        tready_o = 1'b1;
        tick();
        tready_o = 1'b0;
        check("single_pop_tvalid", 32'(tvalid_o), 32'd0);
        check("single_pop_level",  32'(level),    32'd0);

        // Fill, almost-full, ordering.
        for (int i = 1; i <= 8; i++) begin
            write_word(8'(i));
            check("fill_level", 32'(level),       32'(i));
            check("fill_afull", 32'(almost_full), (i >= 6) ? 32'd1 : 32'd0);
        end
        for (int i = 1; i <= 8; i++) exp_q.push_back(8'(i));
        drain_expect("fill_drain");
        check("fill_afull_clr", 32'(almost_full), 32'd0);

        // Overflow.
        for (int i = 0; i < 8; i++) write_word(8'h31 + 8'(i));
        check("ovf_full_level", 32'(level), 32'd8);
        write_word(8'hEE);
        check("ovf_set",   32'(overflow), 32'd1);
        check("ovf_level", 32'(level),    32'd8);
        check("ovf_head",  32'(tdata_o),  32'h31);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);
        overflow_clr = 1'b1;
        write_word(8'hEE);
        overflow_clr = 1'b0;
        check("ovf_clr_vs_drop", 32'(overflow), 32'd1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check("ovf_clr2", 32'(overflow), 32'd0);

        // Full with simultaneous push and pop.
        tready_o = 1'b1;
        write_word(8'h99);
        tready_o = 1'b0;
        check("pp_level", 32'(level),    32'd8);
        check("pp_ovf",   32'(overflow), 32'd0);
        for (int i = 1; i < 8; i++) exp_q.push_back(8'h31 + 8'(i));
        exp_q.push_back(8'h99);
        drain_expect("pp_drain");

        // Wrap-around: a word every other cycle, tready_o toggling every cycle.
        rx_cnt = 0;
        k = 0;
        for (int c = 0; c < 120 && (k < 20 || exp_q.size() > 0); c++) begin
            tready_o = c[0];
            if (c[0] == 1'b0 && k < 20) begin
                tvalid_i = 1'b1;
                tdata_i  = 8'h10 + 8'(k);
            end else begin
                tvalid_i = 1'b0;
            end
            if (tvalid_o && tready_o) begin
                if (exp_q.size() == 0) begin
                    check("wrap_unexpected", 32'(tdata_o), 32'hFFFF_FFFF);
                end else begin
                    check("wrap_tdata", 32'(tdata_o), 32'(exp_q.pop_front()));
                    rx_cnt++;
                end
            end
            tick();
            if (tvalid_i) begin
                exp_q.push_back(tdata_i);
                k++;
            end
        end
        tvalid_i = 1'b0;
        tready_o = 1'b0;
        check("wrap_left",  32'(exp_q.size()), 32'd0);
        check("wrap_count", 32'(rx_cnt),       32'd20);
        check("wrap_level", 32'(level),        32'd0);
        check("wrap_ovf",   32'(overflow),     32'd0);
        check("wrap_tdata0", 32'(tdata_o),     32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
